mux_rr_pipe: RTL and testbench
==============================

// Module: mux_rr_pipe
// PURPOSE
//   Parametrised successor of the 32-bit 4:1 select mux. Selects one of NCH
//   WIDTH-bit input channels, either statically via S or by round-robin
//   arbitration, and delivers it through one registered valid/ready stage.
//   Used where several datapath producers (ALU, memory, CSR reads) share a
//   single write-back or bus path and must be back-pressured.
// PARAMETERS
//   WIDTH   32  data width per channel, >=1
//   NCH     4   number of input channels, 2..16
//   SELW    2   select width, = clog2(NCH); the instantiator sets it consistently
// PORTS
//   CLK       in   1           clock, all state updates on rising edge
//   CLRN      in   1           reset, synchronous, active-low
//   MODE      in   1           0 = fixed select by S, 1 = round-robin
//   S         in   SELW        channel select, used when MODE=0
//   IN_DATA   in   NCH*WIDTH   channel k occupies bits [k*WIDTH +: WIDTH]
//   IN_VALID  in   NCH         per-channel valid
//   IN_READY  out  NCH         per-channel ready, at most one bit high
//   OUT_DATA  out  WIDTH       registered selected data
//   OUT_CH    out  SELW        channel index of OUT_DATA
//   OUT_VALID out  1           OUT_DATA/OUT_CH hold a beat
//   OUT_READY in   1           downstream accepts the beat
// BEHAVIOUR
//   - Reset (CLRN=0 at a rising edge): OUT_VALID=0, OUT_DATA=0, OUT_CH=0,
//     rr pointer PTR=NCH-1, so channel 0 has top priority after reset.
//     IN_READY=0 while CLRN=0. Reset mid-transfer drops the held beat.
//   - load_en = !OUT_VALID | OUT_READY. This is a combinational path from
//     OUT_READY to IN_READY, with no skid buffer.
//   - Grant g is computed combinationally each cycle:
//       MODE=0: g=S if IN_VALID[S]=1, else no grant. Other channels are
//               never granted. If S>=NCH, there is no grant.
//       MODE=1: g = first k with IN_VALID[k]=1, scanning
//               k = PTR+1, PTR+2, ... mod NCH (wrap-around). No valid
//               input means no grant.
//   - IN_READY[g] = load_en when a grant exists; all other IN_READY bits are 0.
//   - Accept (IN_VALID[g] & IN_READY[g]): at the next edge OUT_DATA<=ch g
//     data, OUT_CH<=g, OUT_VALID<=1. In MODE=1 only, PTR<=g. PTR is
//     unchanged in MODE=0.
//   - load_en=1 with no grant: at the next edge OUT_VALID<=0. OUT_DATA and
//     OUT_CH hold their values.
//   - load_en=0: OUT_DATA, OUT_CH, OUT_VALID and PTR hold. A stalled beat
//     stays stable until it is taken.
//   - Latency is 1 cycle from accept to OUT_VALID. With OUT_READY held
//     high, throughput is 1 beat per cycle.
//   - MODE and S are sampled in the cycle of the grant. Changing them never
//     alters a beat already in the output register.
//   - A simultaneous output take and new accept in one cycle is legal, and
//     the new beat replaces the old one at that edge.
//   - Inputs must hold IN_VALID and IN_DATA until accepted. The block does not
//     check this.
// TESTING
//   T1 reset: CLRN=0 for 2 cycles with all IN_VALID=1 -> OUT_VALID=0,
//      OUT_DATA=0, IN_READY=0; after release in MODE=1, first OUT_CH=0.
//   T2 fixed: MODE=0, S=2, ch2=32'hDEADBEEF valid, ch0/1/3 valid, OUT_READY=1
//      -> IN_READY=4'b0100, next cycle OUT_DATA=32'hDEADBEEF, OUT_CH=2.
//   T3 round-robin: MODE=1, all 4 valid, OUT_READY=1 for 8 cycles
//      -> OUT_CH sequence 0,1,2,3,0,1,2,3, with a beat every cycle.
//   T4 skip/wrap: MODE=1, PTR=2, only ch1 and ch3 valid -> grants 3, then
//      1, then 3.
//   T5 backpressure: OUT_VALID=1 holding 32'h5, OUT_READY=0 for 3 cycles
//      -> IN_READY=0 and OUT_DATA=32'h5 held; OUT_READY=1 -> new beat next edge.
//   T6 drain/mode switch: MODE=1 to 0 while a beat is stalled -> the stalled beat
//      is unchanged; with no valid inputs and OUT_READY=1 -> OUT_VALID=0 next cycle.

Source files
------------

// File: rtl/mux_rr_pipe.sv
// NCH-way WIDTH-bit channel mux with a fixed or round-robin grant, feeding one
// registered valid/ready output stage (no skid buffer; OUT_READY reaches IN_READY).
module mux_rr_pipe #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                  CLK,
    input  logic                  CLRN,
    input  logic                  MODE,
    input  logic [SELW-1:0]       S,
    input  logic [NCH*WIDTH-1:0]  IN_DATA,
    input  logic [NCH-1:0]        IN_VALID,
    output logic [NCH-1:0]        IN_READY,
    output logic [WIDTH-1:0]      OUT_DATA,
    output logic [SELW-1:0]       OUT_CH,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  k_sel;
    logic             grant_vld;
    logic             load_en;
    logic [WIDTH-1:0] ch_data [NCH];

    assign load_en = ~OUT_VALID | OUT_READY;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign ch_data[g]  = IN_DATA[g*WIDTH +: WIDTH];
        assign IN_READY[g] = CLRN & load_en & grant_vld & (grant == SELW'(g));
    end

    // Round-robin scans channels above ptr first, then wraps to 0..ptr.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        k_sel     = '0;
        if (!MODE) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                k_sel = SELW'(k);
                if (k_sel == S && IN_VALID[k_sel]) begin
                    grant     = k_sel;
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                k_sel = SELW'(k);
                if (!grant_vld && k_sel > ptr && IN_VALID[k_sel]) begin
                    grant     = k_sel;
                    grant_vld = 1'b1;
                end
            end
            for (int unsigned k = 0; k < NCH; k++) begin
                k_sel = SELW'(k);
                if (!grant_vld && k_sel <= ptr && IN_VALID[k_sel]) begin
                    grant     = k_sel;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_CH    <= '0;
            ptr       <= SELW'(NCH - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                OUT_VALID <= 1'b1;
                OUT_DATA  <= ch_data[grant];
                OUT_CH    <= grant;
                if (MODE) begin
                    ptr <= grant;
                end
            end else begin
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Self-checking bench for mux_rr_pipe: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model of the arbiter.
module tb_mux_rr_pipe;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 clrn;
    logic                 mode;
    logic [SELW-1:0]      s;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     ch_data [NCH];

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = ch_data[k];
    end

    mux_rr_pipe #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .CLK(clk), .CLRN(clrn), .MODE(mode), .S(s),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_CH(out_ch), .OUT_VALID(out_valid),
        .OUT_READY(out_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the beat held at the output and the rr pointer.
    bit          m_known = 0;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_ch;
    int          m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_grant();
        if (!mode) return (int'(s) < NCH && in_valid[s]) ? int'(s) : -1;
        for (int d = 1; d <= NCH; d++) begin
            int k;
            k = (m_ptr + d) % NCH;
            if (in_valid[k]) return k;
        end
        return -1;
    endfunction

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int             g;
        bit             ld;
        logic [NCH-1:0] exp_rdy;
        @(negedge clk);
        ld      = !m_valid || out_ready;
        g       = ref_grant();
        exp_rdy = '0;
        if (clrn && ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (m_known) begin
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("out_data", 64'(out_data), 64'(m_data));
            chk("out_ch", 64'(out_ch), 64'(m_ch));
        end
        @(posedge clk);
        if (!clrn) begin
            m_known = 1;
            m_valid = 0;
            m_data  = '0;
            m_ch    = 0;
            m_ptr   = NCH - 1;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = ch_data[g];
                m_ch    = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    initial begin
        clrn = 1'b0; mode = 1'b1; s = '0; in_valid = '1; out_ready = 1'b1;
        for (int k = 0; k < NCH; k++) ch_data[k] = $urandom;

        // T1 reset with all inputs valid
        #1;
        chk("t1_rdy_in_reset", 64'(in_ready), 64'h0);
        cycle();
        cycle();
        chk("t1_valid", 64'(out_valid), 64'h0);
        chk("t1_data", 64'(out_data), 64'h0);
        clrn = 1'b1;
        cycle();
        chk("t1_first_ch", 64'(out_ch), 64'h0);
        chk("t1_first_valid", 64'(out_valid), 64'h1);

        // T2 fixed select of channel 2
        mode = 1'b0; s = 2'd2; ch_data[2] = 32'hDEADBEEF; in_valid = 4'b1111;
        #1;
        chk("t2_rdy", 64'(in_ready), 64'b0100);
        cycle();
        chk("t2_data", 64'(out_data), 64'hDEADBEEF);
        chk("t2_ch", 64'(out_ch), 64'h2);

        // T3 round-robin from ptr=3 over all channels
        mode = 1'b1; in_valid = 4'b1000;
        cycle();
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t3_ch", 64'(out_ch), 64'(i % NCH));
            chk("t3_valid", 64'(out_valid), 64'h1);
        end

        // T4 skip and wrap from ptr=2 with ch1/ch3 valid
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b1010;
        cycle(); chk("t4_g0", 64'(out_ch), 64'h3);
        cycle(); chk("t4_g1", 64'(out_ch), 64'h1);
        cycle(); chk("t4_g2", 64'(out_ch), 64'h3);

        // T5 backpressure on a beat of 5
        mode = 1'b0; s = 2'd0; in_valid = 4'b0001; ch_data[0] = 32'h5; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_rdy_stall", 64'(in_ready), 64'h0);
            cycle();
            chk("t5_hold", 64'(out_data), 64'h5);
        end
        out_ready = 1'b1; ch_data[0] = 32'h7;
        cycle();
        chk("t5_new", 64'(out_data), 64'h7);

        // T6 mode switch while stalled, then drain
        out_ready = 1'b0; mode = 1'b1; in_valid = 4'b1111;
        for (int k = 0; k < NCH; k++) ch_data[k] = $urandom;
        cycle();
        chk("t6_stall_data", 64'(out_data), 64'h7);
        chk("t6_stall_ch", 64'(out_ch), 64'h0);
        mode = 1'b0; s = 2'd3;
        cycle();
        chk("t6_switch_data", 64'(out_data), 64'h7);
        in_valid = 4'b0000; out_ready = 1'b1;
        cycle();
        chk("t6_drain_valid", 64'(out_valid), 64'h0);
        chk("t6_drain_data", 64'(out_data), 64'h7);

        // Random traffic, including occasional mid-transfer reset
        for (int i = 0; i < 400; i++) begin
            clrn      = ($urandom_range(0, 39) != 0);
            mode      = 1'(($urandom_range(0, 3) != 0) ? 1 : 0);
            s         = SELW'($urandom);
            in_valid  = NCH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < NCH; k++) if ($urandom_range(0, 1) != 0) ch_data[k] = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
